led_digit_scan_ctrl: RTL

//  Scan scheduler for the four-digit seven-segment display. Time-multiplexes four 4-bit chars onto
//  the shared decoder input (char) and anode lines (an3..an0, active-low), with a blanking guard

---
 rtl/led_digit_scan_ctrl_if.sv | 19 +
 rtl/led_digit_scan_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/led_digit_scan_ctrl_if.sv
// Load port bundle for the seven-segment scan controller.
// Carries a 16-bit four-digit display word over a valid/ready handshake.
interface led_digit_scan_ctrl_if;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/led_digit_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with guard blanking and tear-free loads.
// Optional macro BRIGHTNESS_EN adds a per-slot PWM brightness input.
module led_digit_scan_ctrl #(
    parameter int SLOT_CYCLES  = 1000,
    parameter int GUARD_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
`ifdef BRIGHTNESS_EN
    input  logic [3:0]                  bright,
`endif
    led_digit_scan_ctrl_if.slave        ld,
    output logic                        an3,
    output logic                        an2,
    output logic                        an1,
    output logic                        an0,
    output logic [3:0]                  char,
    output logic                        frame_start
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;

    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             ready_q, ready_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       char_q, char_d;
    logic             fs_q, fs_d;

    logic             slot_start;
    logic             frame;
    logic             accept;
    logic             drive_on;

`ifdef BRIGHTNESS_EN
    localparam int D16 = (SLOT_CYCLES - GUARD_CYCLES) / 16;

    logic [3:0]       bright_q, bright_d;
    logic [CNT_W:0]   on_lim;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        digit_d = digit_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            digit_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    digit_d = '0;
                end
                GUARD: begin
                    if (cnt_q == GUARD_LAST)
                        state_d = DRIVE;
                end
                DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = GUARD;
                        cnt_d   = '0;
                        digit_d = digit_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    digit_d = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so the registered
    // versions line up with the cycle that state occupies.
    always_comb begin
        slot_start = (state_d == GUARD) && (cnt_d == '0);
        frame      = slot_start && (digit_d == 2'd0);
        accept     = ld.load_valid && ready_q;

        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;

        if (accept) begin
            pend_d     = ld.load_data;
            pend_vld_d = 1'b1;
        end

        if (frame && (pend_vld_q || accept)) begin
            disp_d     = accept ? ld.load_data : pend_q;
            pend_vld_d = 1'b0;
        end else if ((state_q == IDLE) && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end

        ready_d = !pend_vld_q && !accept;

        char_d = char_q;
        if (slot_start)
            char_d = disp_d[{digit_d, 2'b00} +: 4];

        fs_d = frame;

`ifdef BRIGHTNESS_EN
        bright_d = slot_start ? bright : bright_q;
        on_lim   = (CNT_W+1)'(GUARD_CYCLES + (int'(bright_q) + 1) * D16);
        drive_on = ({1'b0, cnt_d} < on_lim);
`else
        drive_on = 1'b1;
`endif

        an_d = 4'hF;
        if ((state_d == DRIVE) && drive_on)
            an_d = ~(4'b0001 << digit_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            an_q       <= 4'hF;
            char_q     <= '0;
            fs_q       <= 1'b0;
        end else begin
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ready_q    <= ready_d;
            an_q       <= an_d;
            char_q     <= char_d;
            fs_q       <= fs_d;
        end
    end

`ifdef BRIGHTNESS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bright_q <= 4'hF;
        else
            bright_q <= bright_d;
    end
`endif

    assign an3           = an_q[3];
    assign an2           = an_q[2];
    assign an1           = an_q[1];
    assign an0           = an_q[0];
    assign char          = char_q;
    assign frame_start   = fs_q;
    assign ld.load_ready = ready_q;

endmodule
